srl_fifo_ctrl: RTL

//  First-word-fall-through FIFO, depth up to 32, built on an addressable shift-register store.
//  Its storage is the 32-bit addressable shift primitive: push drives the shift enable and
//  the read address selects the oldest entry. Sits between a bursty producer and a

---
 rtl/srl_fifo_ctrl_pkg.sv | 41 ++++
 rtl/srl_shift_array.sv | 54 +++++
 rtl/srl_fifo_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/srl_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl_pkg
//  Description : Shared constants and sizing helpers for the shift-register
//                FIFO. These are the FIFO depth, the occupancy counter width,
//                the default almost-full level and the registered flag bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package srl_fifo_ctrl_pkg;

    // The largest supported depth. One addressable shift primitive holds 32 bits.
    localparam int unsigned SRL_MAX_DEPTH_LOG2 = 5;
    localparam int unsigned SRL_MAX_DEPTH      = 32;

    // Number of entries for a given log2 depth.
    function automatic int unsigned fifo_depth(input int unsigned depth_log2);
        return 32'd1 << depth_log2;
    endfunction

    // The occupancy counter must represent 0..DEPTH inclusive, so it needs one bit more.
    function automatic int unsigned count_width(input int unsigned depth_log2);
        return depth_log2 + 32'd1;
    endfunction

    // Default almost-full level, which leaves four free slots. Very shallow
    // FIFOs have no room for that margin, so for them the level is clamped to full.
    function automatic int unsigned afull_default(input int unsigned depth_log2);
        int unsigned depth;
        depth = fifo_depth(depth_log2);
        return (depth > 32'd4) ? (depth - 32'd4) : depth;
    endfunction

    // Handshake and status flags. All of them are registered.
    typedef struct packed {
        logic in_ready;
        logic out_valid;
        logic almost_full;
    } fifo_flags_t;

endpackage : srl_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/srl_shift_array.sv
`default_nettype none
// ============================================================================
//  Module      : srl_shift_array
//  Description : WIDTH independent bit lanes. Each lane is a DEPTH-deep shift
//                register. All lanes share one shift enable and one read
//                address. There is no reset, so each lane maps onto a single
//                addressable shift-register primitive.
//  Ports       : clk       - rising-edge clock
//                shift_en  - shift every lane up one index and load shift_in
//                            at index 0
//                shift_in  - word written at index 0 on a shift
//                rd_addr   - index that is read, common to all lanes
//                rd_data   - combinational read of index rd_addr
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_shift_array
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [WIDTH-1:0]      shift_in,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    localparam int DEPTH = int'(fifo_depth(DEPTH_LOG2));

    generate
        for (genvar b = 0; b < WIDTH; b++) begin : g_lane
            logic [DEPTH-1:0] lane_q;
            logic [DEPTH-1:0] lane_d;

            always_comb begin
                lane_d = lane_q;
                if (shift_en) begin
                    lane_d = {lane_q[DEPTH-2:0], shift_in[b]};
                end
            end

            // The contents are not reset. After reset, the reset occupancy
            // count guarantees that no stale entry is ever presented.
            always_ff @(posedge clk) begin
                lane_q <= lane_d;
            end

            assign rd_data[b] = lane_q[rd_addr];
        end
    endgenerate

endmodule : srl_shift_array
`default_nettype wire

// File: rtl/srl_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : srl_fifo_ctrl
//  Description : First-word-fall-through FIFO built on an addressable shift
//                register store. A push shifts the store. The oldest entry
//                sits at index count-1 and is read combinationally. All
//                handshake and status flags are registered from the
//                next-state occupancy.
//  Ports       : clk         - rising-edge clock
//                rst_n       - asynchronous active-low reset
//                in_data     - write data
//                in_valid    - producer offers in_data
//                in_ready    - FIFO accepts; push = in_valid & in_ready
//                out_data    - oldest entry (meaningful while out_valid)
//                out_valid   - FIFO is non-empty
//                out_ready   - consumer takes; pop = out_valid & out_ready
//                count       - current occupancy, 0..2**DEPTH_LOG2
//                almost_full - count >= AFULL_LEVEL
//  Revision    : 1.0 - initial release
// ============================================================================
module srl_fifo_ctrl
    import srl_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH_LOG2  = 5,
    parameter int AFULL_LEVEL = int'(afull_default(DEPTH_LOG2))
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WIDTH-1:0]        in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    almost_full
);

    localparam int DEPTH = int'(fifo_depth(DEPTH_LOG2));
    localparam int CW    = int'(count_width(DEPTH_LOG2));

    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    fifo_flags_t           flags_q;
    fifo_flags_t           flags_d;
    logic                  push;
    logic                  pop;
    logic [DEPTH_LOG2-1:0] rd_addr;

    // The handshakes are qualified only by registered flags. Because of this,
    // the count can never wrap, and no flag has a combinational path from
    // in_valid or out_ready.
    assign push = in_valid  & flags_q.in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;  // idle, or push+pop: occupancy holds
        endcase
    end

    // Each flag is computed from the next occupancy, so the registered value
    // is exact in the cycle where the new count becomes visible.
    always_comb begin
        flags_d             = '0;
        flags_d.in_ready    = (count_d != CW'(DEPTH));
        flags_d.out_valid   = (count_d != '0);
        flags_d.almost_full = (count_d >= CW'(AFULL_LEVEL));
    end

    // During reset, in_ready is held at 0. It rises on the first edge after
    // release, because the next-state count is then 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            flags_q <= '0;
        end else begin
            count_q <= count_d;
            flags_q <= flags_d;
        end
    end

    // The oldest entry is at index count-1. When the FIFO is empty, the
    // address is parked at 0. On a simultaneous push and pop, the shift moves
    // the next-oldest entry into the same address.
    always_comb begin
        rd_addr = '0;
        if (count_q != '0) begin
            rd_addr = DEPTH_LOG2'(count_q - CW'(1));
        end
    end

    srl_shift_array #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_store (
        .clk      (clk),
        .shift_en (push),
        .shift_in (in_data),
        .rd_addr  (rd_addr),
        .rd_data  (out_data)
    );

    assign in_ready    = flags_q.in_ready;
    assign out_valid   = flags_q.out_valid;
    assign almost_full = flags_q.almost_full;
    assign count       = count_q;

endmodule : srl_fifo_ctrl
`default_nettype wire
